jzjpcc_memory: RTL and testbench

Memory stage of the jzjpcc five-stage pipeline: consumes the execute→memory pipeline register, performs data-memory loads and stores over a request/acknowledge port, formats load data (byte/halfword, signed/unsigned), and registers the result into the memory→writeback pipeline register. Non-memory instructions pass through in one cycle. A memory access holds the upstream stages via `stall` until the data memory acknowledges.

---
 rtl/jzjpcc_memory_if.sv | 20 ++
 rtl/jzjpcc_memory.sv | 136 +++++++++++++
 tb/tb_jzjpcc_memory.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/jzjpcc_memory_if.sv
// rtl/jzjpcc_memory_if.sv - data-memory request/acknowledge port of the jzjpcc memory stage
interface jzjpcc_memory_if #(parameter int RAM_A_WIDTH = 30);
  logic                   dmemRequest;
  logic [RAM_A_WIDTH-1:0] dmemAddress;
  logic                   dmemWriteEnable;
  logic [31:0]            dmemWriteData;
  logic [3:0]             dmemByteMask;
  logic                   dmemAck;
  logic [31:0]            dmemReadData;

  modport master (
    output dmemRequest, dmemAddress, dmemWriteEnable, dmemWriteData, dmemByteMask,
    input  dmemAck, dmemReadData
  );

  modport slave (
    input  dmemRequest, dmemAddress, dmemWriteEnable, dmemWriteData, dmemByteMask,
    output dmemAck, dmemReadData
  );
endinterface

// File: rtl/jzjpcc_memory.sv
// rtl/jzjpcc_memory.sv - jzjpcc memory stage: load/store over req/ack, load formatting, MEM/WB register
module jzjpcc_memory #(
  parameter int RAM_A_WIDTH = 30
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid,
  input  logic [31:0]            aluResult,
  input  logic [4:0]             rdAddr,
  input  logic                   rdWriteEnable,
  input  logic [1:0]             rdSource,
  input  logic                   memoryWriteEnable,
  input  logic [2:0]             funct3,
  input  logic [31:0]            memDataToWrite,
  input  logic [3:0]             memByteMask,
  jzjpcc_memory_if.master        dmem,
  output logic                   stall,
  output logic                   wbValid,
  output logic [4:0]             wbRdAddr,
  output logic                   wbRdWriteEnable,
  output logic [31:0]            wbRdData
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} stateT;

  stateT       state, nextState;
  logic        memOp;
  logic [31:0] aluLatched, writeDataLatched, loadData;
  logic [3:0]  maskLatched, maskComb;
  logic [2:0]  funct3Latched;
  logic [4:0]  rdAddrLatched;
  logic        rdWriteEnableLatched, storeLatched;
  logic        requestComb, writeEnableComb;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign memOp = valid & (memoryWriteEnable | (rdSource == 2'b01));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (memOp) nextState = ACCESS;
      ACCESS:  if (dmem.dmemAck) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // stall depends only on state, decode and ack, never on the wb register
  always_comb begin
    stall           = 1'b0;
    requestComb     = 1'b0;
    writeEnableComb = 1'b0;
    maskComb        = 4'b0000;
    case (state)
      IDLE: stall = memOp;
      ACCESS: begin
        stall           = !dmem.dmemAck;
        requestComb     = 1'b1;
        writeEnableComb = storeLatched;
        maskComb        = maskLatched;
      end
      default: stall = 1'b0;
    endcase
  end

  assign dmem.dmemRequest     = requestComb;
  assign dmem.dmemWriteEnable = writeEnableComb;
  assign dmem.dmemByteMask    = maskComb;
  assign dmem.dmemAddress     = aluLatched[RAM_A_WIDTH+1:2];
  assign dmem.dmemWriteData   = writeDataLatched;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aluLatched           <= 32'h0;
      writeDataLatched     <= 32'h0;
      maskLatched          <= 4'h0;
      funct3Latched        <= 3'h0;
      rdAddrLatched        <= 5'h0;
      rdWriteEnableLatched <= 1'b0;
      storeLatched         <= 1'b0;
    end else if (state == IDLE && memOp) begin
      aluLatched           <= aluResult;
      writeDataLatched     <= memDataToWrite;
      maskLatched          <= memByteMask;
      funct3Latched        <= funct3;
      rdAddrLatched        <= rdAddr;
      rdWriteEnableLatched <= rdWriteEnable;
      storeLatched         <= memoryWriteEnable;
    end
  end

  always_comb begin
    case (aluLatched[1:0])
      2'd0:    loadByte = dmem.dmemReadData[7:0];
      2'd1:    loadByte = dmem.dmemReadData[15:8];
      2'd2:    loadByte = dmem.dmemReadData[23:16];
      default: loadByte = dmem.dmemReadData[31:24];
    endcase
    loadHalf = aluLatched[1] ? dmem.dmemReadData[31:16] : dmem.dmemReadData[15:0];
    case (funct3Latched)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b100:  loadData = {24'h0, loadByte};
      3'b101:  loadData = {16'h0, loadHalf};
      default: loadData = dmem.dmemReadData;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wbValid         <= 1'b0;
      wbRdAddr        <= 5'h0;
      wbRdWriteEnable <= 1'b0;
      wbRdData        <= 32'h0;
    end else if (state == IDLE) begin
      if (memOp) begin
        wbValid         <= 1'b0;
        wbRdWriteEnable <= 1'b0;
      end else begin
        wbValid         <= valid;
        wbRdAddr        <= rdAddr;
        wbRdData        <= aluResult;
        wbRdWriteEnable <= valid & rdWriteEnable & (rdAddr != 5'd0);
      end
    end else if (dmem.dmemAck) begin
      wbValid         <= 1'b1;
      wbRdAddr        <= rdAddrLatched;
      wbRdData        <= storeLatched ? aluLatched : loadData;
      wbRdWriteEnable <= !storeLatched & rdWriteEnableLatched & (rdAddrLatched != 5'd0);
    end
  end
endmodule

// File: tb/tb_jzjpcc_memory.sv
// tb/tb_jzjpcc_memory.sv - randomized self-checking bench for jzjpcc_memory
module tb_jzjpcc_memory;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] aluResult = 32'h0;
  logic [4:0]  rdAddr = 5'h0;
  logic        rdWriteEnable = 1'b0;
  logic [1:0]  rdSource = 2'b00;
  logic        memoryWriteEnable = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] memDataToWrite = 32'h0;
  logic [3:0]  memByteMask = 4'h0;
  logic        stall, wbValid, wbRdWriteEnable;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbRdData;
  int          checks = 0;
  int          errors = 0;

  jzjpcc_memory_if #(.RAM_A_WIDTH(30)) dmemBus ();

  jzjpcc_memory #(.RAM_A_WIDTH(30)) dut (
    .clock(clock), .reset(reset), .valid(valid), .aluResult(aluResult),
    .rdAddr(rdAddr), .rdWriteEnable(rdWriteEnable), .rdSource(rdSource),
    .memoryWriteEnable(memoryWriteEnable), .funct3(funct3),
    .memDataToWrite(memDataToWrite), .memByteMask(memByteMask),
    .dmem(dmemBus.master), .stall(stall), .wbValid(wbValid), .wbRdAddr(wbRdAddr),
    .wbRdWriteEnable(wbRdWriteEnable), .wbRdData(wbRdData)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Architectural meaning of a load: pick the lane by byte offset, then extend.
  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * (o / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic runOp(input logic v, input logic [31:0] alu, input logic [4:0] rd, input logic rdWe,
                       input logic [1:0] rdSrc, input logic memWe, input logic [2:0] f3,
                       input logic [31:0] wdata, input logic [3:0] mask, input int n, input logic [31:0] word);
    logic isMem;
    logic [31:0] expData;
    @(negedge clock);
    valid = v; aluResult = alu; rdAddr = rd; rdWriteEnable = rdWe; rdSource = rdSrc;
    memoryWriteEnable = memWe; funct3 = f3; memDataToWrite = wdata; memByteMask = mask;
    isMem = v & (memWe | (rdSrc == 2'b01));
    dmemBus.dmemAck = isMem ? 1'b0 : 1'($urandom);
    dmemBus.dmemReadData = $urandom;
    #1;
    check("stall_idle", {31'h0, stall}, {31'h0, isMem});
    check("req_idle", {31'h0, dmemBus.dmemRequest}, 32'h0);
    check("mask_idle", {28'h0, dmemBus.dmemByteMask}, 32'h0);
    if (!isMem) begin
      @(posedge clock); #1;
      check("pt_valid", {31'h0, wbValid}, {31'h0, v});
      check("pt_rd", {27'h0, wbRdAddr}, {27'h0, rd});
      check("pt_data", wbRdData, alu);
      check("pt_we", {31'h0, wbRdWriteEnable}, {31'h0, v & rdWe & (rd != 5'd0)});
      return;
    end
    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      // upstream values no longer matter; the access must run off latched state
      aluResult = $urandom; memDataToWrite = $urandom; memByteMask = 4'($urandom);
      funct3 = 3'($urandom); rdAddr = 5'($urandom); valid = 1'($urandom);
      dmemBus.dmemAck = (c == n);
      dmemBus.dmemReadData = (c == n) ? word : $urandom;
      #1;
      check("acc_wbvalid", {31'h0, wbValid}, 32'h0);
      check("acc_req", {31'h0, dmemBus.dmemRequest}, 32'h1);
      check("acc_addr", {2'b00, dmemBus.dmemAddress}, {2'b00, alu[31:2]});
      check("acc_we", {31'h0, dmemBus.dmemWriteEnable}, {31'h0, memWe});
      check("acc_wdata", dmemBus.dmemWriteData, wdata);
      check("acc_mask", {28'h0, dmemBus.dmemByteMask}, {28'h0, mask});
      check("acc_stall", {31'h0, stall}, {31'h0, c != n});
    end
    @(posedge clock); #1;
    expData = memWe ? alu : refLoad(f3, alu[1:0], word);
    check("mem_valid", {31'h0, wbValid}, 32'h1);
    check("mem_rd", {27'h0, wbRdAddr}, {27'h0, rd});
    check("mem_data", wbRdData, expData);
    check("mem_we", {31'h0, wbRdWriteEnable}, {31'h0, !memWe & rdWe & (rd != 5'd0)});
    check("mem_req_done", {31'h0, dmemBus.dmemRequest}, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] f3Table [8];
    f3Table = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    dmemBus.dmemAck = 1'b0;
    dmemBus.dmemReadData = 32'h0;
    #1;
    check("rst_wbvalid", {31'h0, wbValid}, 32'h0);
    check("rst_wbwe", {31'h0, wbRdWriteEnable}, 32'h0);
    check("rst_req", {31'h0, dmemBus.dmemRequest}, 32'h0);
    check("rst_we", {31'h0, dmemBus.dmemWriteEnable}, 32'h0);
    check("rst_mask", {28'h0, dmemBus.dmemByteMask}, 32'h0);
    check("rst_rd", {27'h0, wbRdAddr}, 32'h0);
    check("rst_data", wbRdData, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;

    runOp(1, 32'h12345678, 5'd5, 1, 2'b00, 0, 3'd0, 32'h0, 4'h0, 1, 32'h0);
    check("plan_alu", wbRdData, 32'h12345678);
    runOp(1, 32'h103, 5'd7, 1, 2'b01, 0, 3'd0, 32'h0, 4'h0, 4, 32'h80FF7F01);
    check("plan_lb", wbRdData, 32'hFFFFFF80);
    runOp(1, 32'h103, 5'd7, 1, 2'b01, 0, 3'd4, 32'h0, 4'h0, 4, 32'h80FF7F01);
    check("plan_lbu", wbRdData, 32'h00000080);
    runOp(1, 32'h102, 5'd8, 1, 2'b01, 0, 3'd1, 32'h0, 4'h0, 1, 32'h8001ABCD);
    check("plan_lh", wbRdData, 32'hFFFF8001);
    runOp(1, 32'h100, 5'd8, 1, 2'b01, 0, 3'd5, 32'h0, 4'h0, 1, 32'h8001ABCD);
    check("plan_lhu", wbRdData, 32'h0000ABCD);
    runOp(1, 32'h40, 5'd3, 1, 2'b00, 1, 3'd2, 32'hDEADBEEF, 4'hF, 2, 32'h0);
    check("plan_sw_we", {31'h0, wbRdWriteEnable}, 32'h0);
    runOp(1, 32'h201, 5'd0, 1, 2'b01, 0, 3'd0, 32'h0, 4'h0, 2, 32'h0000C300);
    check("plan_x0_data", wbRdData, 32'hFFFFFFC3);

    // reset in the second ACCESS cycle of a load
    @(negedge clock);
    valid = 1; aluResult = 32'h300; rdAddr = 5'd9; rdWriteEnable = 1; rdSource = 2'b01;
    memoryWriteEnable = 0; funct3 = 3'd2; dmemBus.dmemAck = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_req", {31'h0, dmemBus.dmemRequest}, 32'h0);
    check("abort_wbvalid", {31'h0, wbValid}, 32'h0);
    check("abort_data", wbRdData, 32'h0);
    @(negedge clock);
    reset = 1'b0; valid = 0; dmemBus.dmemAck = 1;
    #1;
    check("abort_stall", {31'h0, stall}, 32'h0);
    @(posedge clock); #1;
    check("abort_ack_ignored", {31'h0, dmemBus.dmemRequest}, 32'h0);
    check("abort_no_wb", {31'h0, wbValid}, 32'h0);
    runOp(1, 32'hCAFEF00D, 5'd12, 1, 2'b00, 0, 3'd0, 32'h0, 4'h0, 1, 32'h0);

    for (int i = 0; i < 300; i++) begin
      runOp(1'($urandom_range(0, 7) != 0), $urandom, 5'($urandom), 1'($urandom),
            2'($urandom), 1'($urandom_range(0, 3) == 0), f3Table[$urandom_range(0, 7)],
            $urandom, 4'($urandom), $urandom_range(1, 4), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
